gray_sync_dec: RTL
==================

GRAY_SYNC_DEC -- requirements
Module: gray_sync_dec

Interface
REQ-001 SHALL have parameter DATA, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have parameter SYNC, default 2, number of synchronizer flop stages (legal range 2..4).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_gray  input  DATA  gray-coded count from a remote gray counter, asynchronous to clk.
REQ-006 SHALL have port ack  input  1  consumer acknowledges one pending increment.
REQ-007 SHALL have port out_gray  output  DATA  synchronized gray value (last sync stage).
REQ-008 SHALL have port out_bin  output  DATA  binary decode of out_gray.
REQ-009 SHALL have port pending  output  DATA  remote count minus local consumed count, modulo 2^DATA.
REQ-010 SHALL have port valid  output  1  high when pending != 0.
REQ-011 SHALL have port err  output  1  sticky flag: multi-bit gray transition detected.

Function
REQ-012 SHALL pass in_gray through a chain of SYNC flops; a stable in_gray change SHALL appear on out_gray exactly SYNC clk edges later.
REQ-013 SHALL compute out_bin combinationally from out_gray: bit DATA-1 equal; bit i = out_bin[i+1] XOR out_gray[i].
REQ-014 SHALL hold a DATA-bit consumed pointer r_rd; pending = out_bin - r_rd, truncated to DATA bits (wrap-around is modular, no saturation).
REQ-015 SHALL increment r_rd by 1 on a clk edge where ack=1 and valid=1; pending and valid SHALL reflect the update on the following cycle.
REQ-016 SHALL ignore ack while valid=0 (r_rd unchanged, no error).
REQ-017 SHALL, when out_bin advances and ack is consumed in the same cycle, apply both: new pending = old pending + advance - 1.
REQ-018 SHALL wrap r_rd from 2^DATA-1 to 0 with no special handling.
REQ-019 SHALL keep a register r_prev of the previous out_gray sample; when out_gray XOR r_prev has more than one bit set, err SHALL assert on the next edge and hold until reset.
REQ-020 SHALL not flag err for a zero-bit or single-bit change, including the wrap transition (e.g. DATA=4: gray 1000 -> 0000).
REQ-021 SHALL treat pending values up to 2^DATA-1 as valid; remote advancing 2^DATA or more unacknowledged counts aliases and is a system-level overflow, not detected here.

Reset
REQ-022 SHALL, while reset_n=0, force all sync stages, r_prev, r_rd and err to 0 immediately, independent of clk.
REQ-023 SHALL present out_gray=0, out_bin=0, pending=0, valid=0, err=0 during and directly after reset.
REQ-024 SHALL, on reset assertion mid-operation, discard pending counts; after release, a nonzero in_gray SHALL appear as pending = decoded in_gray after SYNC edges.

Configuration
REQ-025 SHALL use macro GRAY_ERR_CHK_EN to compile in the error checker.
REQ-026 SHALL, with GRAY_ERR_CHK_EN defined, implement r_prev and err per REQ-019/020.
REQ-027 SHALL, without GRAY_ERR_CHK_EN, omit r_prev and tie err to constant 0; all other behaviour is unchanged.

Verification (DATA=4, SYNC=2)
REQ-028 SHALL cover: reset release, in_gray=0000, ack=0 -> all outputs 0 for 10 cycles.
REQ-029 SHALL cover: in_gray steps 0000->0001->0011 (bin 1,2), ack=0 -> out_bin=2, pending=2, valid=1 two edges after last step; err=0.
REQ-030 SHALL cover: pending=2, ack held 3 cycles -> pending 1, 0, 0; valid falls after second ack; third ack ignored, r_rd=2.
REQ-031 SHALL cover: remote counts 14,15,0,1 with acks keeping pace -> pending never exceeds 1 across wrap, err=0, final out_bin=1.
REQ-032 SHALL cover: in_gray jump 0000->0011 (two bits) -> err=1 SYNC+1 edges later, stays 1 after further legal steps; with GRAY_ERR_CHK_EN undefined, err stays 0.
REQ-033 SHALL cover: reset_n pulsed low mid-cycle with pending=5 -> outputs 0 immediately without clk edge; after release with in_gray=0111 (bin 5) -> pending=5 two edges later.

Source files
------------

// File: rtl/gray_sync_dec.sv
// Gray-code crossing receiver: synchronizes a remote gray counter into the
// local clock domain, decodes it to binary and tracks how many remote counts
// the local consumer has not yet acknowledged.
// Optional multi-bit-transition checker: define GRAY_ERR_CHK_EN to build it.
// Without it, err is tied low.

module gray_sync_dec #(
    parameter int unsigned DATA = 4,
    parameter int unsigned SYNC = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [DATA-1:0] in_gray,
    input  logic            ack,
    output logic [DATA-1:0] out_gray,
    output logic [DATA-1:0] out_bin,
    output logic [DATA-1:0] pending,
    output logic            valid,
    output logic            err
);

    localparam logic [DATA-1:0] One = DATA'(1);

    // Stage 0 captures the asynchronous input; stage SYNC-1 is the usable value.
    logic [SYNC-1:0][DATA-1:0] sync_q;

    // Count of remote increments already consumed locally (wraps freely).
    logic [DATA-1:0] rd_q;
    logic [DATA-1:0] rd_d;

    // Synchronizer chain: shift one stage per clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], in_gray};
        end
    end

    assign out_gray = sync_q[SYNC-1];

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        out_bin = '0;
        for (int unsigned i = 0; i < DATA; i++) begin
            out_bin[i] = ^(out_gray >> i);
        end
    end

    // Outstanding counts; modular subtraction keeps wrap-around seamless.
    assign pending = out_bin - rd_q;
    assign valid   = |pending;

    // Consume one count per acknowledged cycle, only when something is pending.
    always_comb begin
        rd_d = rd_q;
        if (ack && valid) begin
            rd_d = rd_q + One;
        end
    end

    // Consumed-pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

`ifdef GRAY_ERR_CHK_EN
    logic [DATA-1:0] prev_q;
    logic [DATA-1:0] diff;
    logic            multi_bit;
    logic            err_q;

    // A legal gray step flips exactly one bit; x & (x-1) is nonzero iff >1 bit set.
    assign diff      = out_gray ^ prev_q;
    assign multi_bit = |(diff & (diff - One));

    // Remember the previous synchronized sample and latch any illegal step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= out_gray;
            if (multi_bit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
